// File: rtl/int_div.sv
// Sequential unsigned restoring divider: DW-bit dividend by VW-bit divisor,
// one quotient bit per clock, with a single-cycle divide-by-zero path.
module int_div #(
    parameter int DW = 13,
    parameter int VW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dz
);

    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] dq;
    logic [VW-1:0] dvs;
    logic [VW-1:0] prem;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          zero_div;
    logic [VW:0]   shifted;
    logic [VW:0]   step;
    logic [DW-1:0] dq_next;

    // Returns {quotient_bit, new_remainder}. The remainder is always below the
    // divisor, so only the low VW bits of the VW+1-bit trial are kept; the
    // low bits of the difference do not depend on the dropped top bit.
    function automatic logic [VW:0] restore_step(input logic [VW:0]   trial,
                                                 input logic [VW-1:0] d);
        logic          no_borrow;
        logic [VW-1:0] rem;
        no_borrow = (trial >= {1'b0, d});
        rem       = trial[VW-1:0] - (no_borrow ? d : '0);
        return {no_borrow, rem};
    endfunction

    assign accept   = start && (state != RUN);
    assign zero_div = (divisor == '0);
    assign shifted  = {prem, dq[DW-1]};
    assign step     = restore_step(shifted, dvs);
    assign dq_next  = {dq[DW-2:0], step[VW]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = zero_div ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq        <= '0;
            dvs       <= '0;
            prem      <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
        end else if (accept) begin
            if (zero_div) begin
                quotient  <= '1;
                remainder <= '0;
                dz        <= 1'b1;
            end else begin
                dq   <= dividend;
                dvs  <= divisor;
                prem <= '0;
                cnt  <= CW'(DW - 1);
            end
        end else if (state == RUN) begin
            dq   <= dq_next;
            prem <= step[VW-1:0];
            if (cnt == '0) begin
                quotient  <= dq_next;
                remainder <= step[VW-1:0];
                dz        <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule
